// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo datapath blocks.
//  - Opcode encodings issued by the reservation stations.
//  - NOT_READY: operand sentinel used by the stations ("value not yet produced").
//  - State encoding of the MUL/DIV execution unit FSM.
package tomasulo_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  localparam logic [8:0] NOT_READY = 9'h1FF;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMulWait = 2'd1,
    StDivIter = 2'd2,
    StDone    = 2'd3
  } exec_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//  rem_in   in  WIDTH  partial remainder from the previous step (always < divisor)
//  divisor  in  WIDTH  divisor (non-zero)
//  next_bit in  1      next dividend bit, shifted in at the LSB
//  rem_out  out WIDTH  new partial remainder
//  q_bit    out 1      quotient bit produced by this step
module div_step #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_in, next_bit};
    diff    = shifted - {1'b0, divisor};
    // No borrow out of the top bit means shifted >= divisor.
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mul_div_exec_unit.sv
// Multi-cycle MUL/DIV functional unit, responder side of the reservation-station dispatch
// interface. Accepts one op in IDLE, returns a one-cycle done strobe with the result, and
// echoes dest/label for the CDB broadcast.
// Ports:
//  clk, rst            clock, asynchronous active-high reset
//  run                 dispatch request, sampled only in IDLE
//  op_x, op_y          operands (unsigned)
//  opcode              OP_MUL / OP_DIV, anything else is reported as illegal
//  dest_in, label_in   destination register and issuing station label
//  result              computed value, valid with done and held afterwards
//  done                one-cycle completion strobe
//  dest_out, label_out latched dest/label of the completing op
//  busy                high from accept through the done cycle
//  div_zero            DIV with op_y == 0 (held until next accept)
//  illegal_op          opcode was not MUL/DIV (held until next accept)
module mul_div_exec_unit
  import tomasulo_pkg::*;
#(
  parameter int unsigned WIDTH   = 9,
  parameter int unsigned REG_W   = 3,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] op_x,
  input  logic [WIDTH-1:0] op_y,
  input  logic [2:0]       opcode,
  input  logic [REG_W-1:0] dest_in,
  input  logic [TAG_W-1:0] label_in,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic [REG_W-1:0] dest_out,
  output logic [TAG_W-1:0] label_out,
  output logic             busy,
  output logic             div_zero,
  output logic             illegal_op
);

  localparam int unsigned CntMax = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  exec_state_e      state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // a_q holds op_x; during DIV it doubles as the dividend/quotient shift register.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [REG_W-1:0] dest_q, dest_d;
  logic [TAG_W-1:0] label_q, label_d;
  logic             div_zero_q, div_zero_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] mul_a, mul_b, mul_prod;
  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;

  // Operands stay latched while waiting; the product is sampled into result on the way
  // to DONE. With MUL_LAT == 1 that happens on the accept edge, straight from the inputs.
  always_comb begin
    mul_a    = (state_q == StIdle) ? op_x : a_q;
    mul_b    = (state_q == StIdle) ? op_y : b_q;
    mul_prod = mul_a * mul_b;  // low WIDTH bits only, overflow dropped
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_in  (rem_q),
    .divisor (b_q),
    .next_bit(a_q[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    result_d   = result_q;
    dest_d     = dest_q;
    label_d    = label_q;
    div_zero_d = div_zero_q;
    illegal_d  = illegal_q;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          a_d        = op_x;
          b_d        = op_y;
          rem_d      = '0;
          dest_d     = dest_in;
          label_d    = label_in;
          div_zero_d = 1'b0;
          illegal_d  = 1'b0;
          if (opcode == OP_MUL) begin
            if (MUL_LAT <= 1) begin
              result_d = mul_prod;
              state_d  = StDone;
            end else begin
              cnt_d   = CntW'(MUL_LAT - 2);
              state_d = StMulWait;
            end
          end else if (opcode == OP_DIV) begin
            if (op_y == '0) begin
              result_d   = '1;
              div_zero_d = 1'b1;
              state_d    = StDone;
            end else begin
              cnt_d   = CntW'(WIDTH - 1);
              state_d = StDivIter;
            end
          end else begin
            result_d  = '0;
            illegal_d = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StMulWait: begin
        if (cnt_q == '0) begin
          result_d = mul_prod;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDivIter: begin
        // Dividend bits leave at the MSB while quotient bits enter at the LSB.
        a_d   = {a_q[WIDTH-2:0], step_q_bit};
        rem_d = step_rem;
        if (cnt_q == '0) begin
          result_d = {a_q[WIDTH-2:0], step_q_bit};
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      result_q   <= '0;
      dest_q     <= '0;
      label_q    <= '0;
      div_zero_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      result_q   <= result_d;
      dest_q     <= dest_d;
      label_q    <= label_d;
      div_zero_q <= div_zero_d;
      illegal_q  <= illegal_d;
    end
  end

  assign result     = result_q;
  assign done       = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign dest_out   = dest_q;
  assign label_out  = label_q;
  assign div_zero   = div_zero_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_mul_div_exec_unit.sv
module tb_mul_div_exec_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [8:0] op_x, op_y;
  logic [2:0] opcode;
  logic [2:0] dest_in, label_in;
  logic [8:0] result;
  logic       done;
  logic [2:0] dest_out, label_out;
  logic       busy, div_zero, illegal_op;

  int errors = 0;
  int checks = 0;

  mul_div_exec_unit #(
    .WIDTH  (9),
    .REG_W  (3),
    .TAG_W  (3),
    .MUL_LAT(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .op_x      (op_x),
    .op_y      (op_y),
    .opcode    (opcode),
    .dest_in   (dest_in),
    .label_in  (label_in),
    .result    (result),
    .done      (done),
    .dest_out  (dest_out),
    .label_out (label_out),
    .busy      (busy),
    .div_zero  (div_zero),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] opc;
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] dst;
    logic [2:0] lbl;
    logic [8:0] res;
    int         lat;
    bit         dz;
    bit         il;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts cycles (sampled on negedge) after an accept edge until done is seen.
  // lat = 0 means done never arrived within the bound.
  task automatic wait_done(input bit scramble, output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = i;
        break;
      end
      if (scramble) begin
        op_x   = 9'($urandom);
        op_y   = 9'($urandom);
        opcode = 3'($urandom);
      end
    end
  endtask

  task automatic issue(input logic [2:0] opc, input logic [8:0] x, input logic [8:0] y,
                       input logic [2:0] dst, input logic [2:0] lbl);
    @(negedge clk);
    opcode = opc; op_x = x; op_y = y; dest_in = dst; label_in = lbl;
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " result"}, int'(result), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " dest_out"}, int'(dest_out), 0);
    chk({tag, " label_out"}, int'(label_out), 0);
    chk({tag, " div_zero"}, int'(div_zero), 0);
    chk({tag, " illegal_op"}, int'(illegal_op), 0);
  endtask

  initial begin
    int lat, bc, seen;

    vecs[0]  = '{3'b010, 9'd12,  9'd11, 3'd2, 3'd3, 9'd132, 3,  1'b0, 1'b0};
    vecs[1]  = '{3'b010, 9'd40,  9'd20, 3'd1, 3'd4, 9'd288, 3,  1'b0, 1'b0};
    vecs[2]  = '{3'b010, 9'd511, 9'd511, 3'd7, 3'd5, 9'd1,  3,  1'b0, 1'b0};
    vecs[3]  = '{3'b010, 9'd0,   9'd77, 3'd3, 3'd3, 9'd0,   3,  1'b0, 1'b0};
    vecs[4]  = '{3'b011, 9'd100, 9'd7,  3'd4, 3'd4, 9'd14,  10, 1'b0, 1'b0};
    vecs[5]  = '{3'b011, 9'd511, 9'd1,  3'd5, 3'd5, 9'd511, 10, 1'b0, 1'b0};
    vecs[6]  = '{3'b011, 9'd5,   9'd9,  3'd6, 3'd3, 9'd0,   10, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 9'd255, 9'd16, 3'd2, 3'd4, 9'd15,  10, 1'b0, 1'b0};
    vecs[8]  = '{3'b011, 9'd55,  9'd0,  3'd1, 3'd5, 9'h1FF, 1,  1'b1, 1'b0};
    vecs[9]  = '{3'b000, 9'd3,   9'd4,  3'd2, 3'd3, 9'd0,   1,  1'b0, 1'b1};
    vecs[10] = '{3'b111, 9'd9,   9'd9,  3'd6, 3'd4, 9'd0,   1,  1'b0, 1'b1};
    vecs[11] = '{3'b011, 9'd300, 9'd300, 3'd7, 3'd5, 9'd1,  10, 1'b0, 1'b0};

    rst = 1'b1; run = 1'b0;
    op_x = '0; op_y = '0; opcode = '0; dest_in = '0; label_in = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle busy", int'(busy), 0);

    foreach (vecs[k]) begin
      issue(vecs[k].opc, vecs[k].x, vecs[k].y, vecs[k].dst, vecs[k].lbl);
      wait_done(1'b0, lat, bc);
      chk($sformatf("v%0d latency", k), lat, vecs[k].lat);
      chk($sformatf("v%0d busy_cycles", k), bc, vecs[k].lat);
      chk($sformatf("v%0d result", k), int'(result), int'(vecs[k].res));
      chk($sformatf("v%0d dest_out", k), int'(dest_out), int'(vecs[k].dst));
      chk($sformatf("v%0d label_out", k), int'(label_out), int'(vecs[k].lbl));
      chk($sformatf("v%0d div_zero", k), int'(div_zero), int'(vecs[k].dz));
      chk($sformatf("v%0d illegal_op", k), int'(illegal_op), int'(vecs[k].il));
      @(negedge clk);
      chk($sformatf("v%0d done_fell", k), int'(done), 0);
      chk($sformatf("v%0d busy_fell", k), int'(busy), 0);
      chk($sformatf("v%0d result_held", k), int'(result), int'(vecs[k].res));
      chk($sformatf("v%0d flag_held", k), int'(div_zero | illegal_op),
          int'(vecs[k].dz | vecs[k].il));
    end

    // run held high through a DIV while the inputs wander: latched operands must win.
    @(negedge clk);
    opcode = 3'b011; op_x = 9'd200; op_y = 9'd3; dest_in = 3'd6; label_in = 3'd4;
    run = 1'b1;
    @(posedge clk);
    wait_done(1'b1, lat, bc);
    chk("hold latency", lat, 10);
    chk("hold result", int'(result), 66);
    chk("hold dest_out", int'(dest_out), 6);
    chk("hold label_out", int'(label_out), 4);
    opcode = 3'b010; op_x = 9'd3; op_y = 9'd5; dest_in = 3'd1; label_in = 3'd3;
    @(negedge clk);
    chk("hold idle gap busy", int'(busy), 0);
    chk("hold idle gap result", int'(result), 66);
    @(posedge clk);
    #1 run = 1'b0;
    wait_done(1'b0, lat, bc);
    chk("reaccept latency", lat, 3);
    chk("reaccept result", int'(result), 15);
    chk("reaccept label_out", int'(label_out), 3);

    // Reset in the middle of a DIV: abort, no done, outputs cleared.
    issue(3'b011, 9'd100, 9'd7, 3'd4, 3'd4);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1 if (done) seen++;
    end
    rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    chk_reset_outputs("midrst hold");
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("midrst no_done", seen, 0);
    issue(3'b010, 9'd7, 9'd9, 3'd5, 3'd5);
    wait_done(1'b0, lat, bc);
    chk("post_rst latency", lat, 3);
    chk("post_rst result", int'(result), 63);
    chk("post_rst dest_out", int'(dest_out), 5);
    chk("post_rst label_out", int'(label_out), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
